fault_campaign_ctrl: RTL and testbench
======================================

Name: fault_campaign_ctrl

Overview:
Sequencer for single-fault injection campaigns on the fault-injectable adder datapath with mod-3 residue checking. It holds one operand pair on the DUT and first runs a fault-free baseline. It then walks a one-hot fault vector across every gate-level fault site, waits a settle interval, samples the DUT sum and its residue-checker flag, and classifies each site. Per-site records stream out over a valid/ready handshake, and per-class counters are kept. It replaces the delay-driven bench sequencing with synthesizable control.

Parameters:
N_SITES, 20, number of fault sites (one err bit each; 4-bit ripple adder = 4 x 5)
OP_W, 4, operand width
SETTLE, 2, settle cycles after applying a fault before sampling (>=1)
CNT_W, 8, width of outcome counters
SITE_W, $clog2(N_SITES), width of the site index

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin campaign; accepted only in IDLE
abort  in  1  synchronous abort; returns to IDLE
a_in  in  OP_W  operand A, latched on start
b_in  in  OP_W  operand B, latched on start
cin_in  in  1  carry-in, latched on start
dut_a  out  OP_W  operand A to DUT
dut_b  out  OP_W  operand B to DUT
dut_cin  out  1  carry-in to DUT
err_vec  out  N_SITES  fault-injection vector to DUT
dut_result  in  OP_W+1  {carry_out, sum} from DUT
dut_err_det  in  1  residue-checker mismatch flag from DUT
rec_valid  out  1  per-site record valid
rec_ready  in  1  record consumer ready
rec_site  out  SITE_W  site index of record
rec_class  out  2  outcome class of record
busy  out  1  campaign in progress
done  out  1  one-cycle pulse at campaign end
golden_fail  out  1  baseline run failed; sticky until next start
n_masked, n_detected, n_silent, n_false  out  CNT_W each  outcome counters

Behaviour:
- Reset (async, rst_n=0): state IDLE. err_vec=0, dut_a/b/cin=0, rec_valid=0, busy=0, done=0, golden_fail=0, all counters 0. err_vec clears combinationally-fast, with no clock needed.
- Golden value = a_in + b_in + cin_in, computed at OP_W+1 bits and latched with the operands at start.
- Classes: MASKED=0 (result == golden, det=0), DETECTED=1 (result != golden, det=1), SILENT=2 (result != golden, det=0), FALSE_ALARM=3 (result == golden, det=1).
- IDLE: on start, latch operands and golden, clear counters and golden_fail, set busy, set baseline flag, site=0, go to APPLY. start is ignored outside IDLE.
- APPLY (1 cycle): err_vec = 0 if baseline, else 1<<site. Load the settle counter with SETTLE.
- SETTLE (SETTLE cycles): err_vec and operands are held.
- SAMPLE (1 cycle): register dut_result and dut_err_det, then classify.
  - Baseline with class != MASKED: set golden_fail and go to DONE.
  - Baseline with class MASKED: clear baseline flag and go to APPLY with site 0.
  - Fault site: go to REPORT.
- REPORT: rec_valid=1 with rec_site and rec_class stable. err_vec is held until the handshake.
  - On rec_valid & rec_ready, the matching counter increments and saturates at 2^CNT_W-1.
  - If site == N_SITES-1, go to DONE; else site++ and go to APPLY.
- DONE (1 cycle): done=1, err_vec=0, busy=0 next cycle, then IDLE. Counters and golden_fail hold until the next start.
- Timing with rec_ready tied high: done asserts (SETTLE+2) + N_SITES*(SETTLE+3) + 1 cycles after the start-accept edge. Defaults give 105.
- abort (any non-IDLE state): next cycle IDLE, err_vec=0, rec_valid=0, busy=0, no done pulse. Counters keep their partial values.
- abort has priority over the handshake completing in the same cycle; that record is not counted.
- Operands and dut_* outputs are stable from APPLY of the baseline until DONE.

Decomposition:
- Package fault_pkg:
  - state enum {IDLE, APPLY, SETTLE, SAMPLE, REPORT, DONE}
  - outcome class enum (2 bits, encodings above)
  - CLASS_W=2
- Sub-module sat_counter (CNT_W, inc, clear, async rst_n), instanced four times. The FSM, classifier and site counter stay in the top.

Test Plan:
1. Ideal DUT model (ignores err_vec, det=0), a=9, b=1, cin=0, rec_ready=1 -> 20 records with sites 0..19, all MASKED; n_masked=20, others 0; done at cycle 105; golden_fail=0.
2. Model flips sum[0] and raises det when err_vec[3]=1 -> record site 3 class DETECTED; n_detected=1, n_masked=19.
3. Model flips sum[1] with det=0 at site 7, and raises det with a correct sum at site 12 -> site 7 SILENT, site 12 FALSE_ALARM; n_silent=1, n_false=1, n_masked=18.
4. Model returns 11 with err_vec=0 -> golden_fail=1, done at cycle SETTLE+3=5, no rec_valid, counters 0.
5. rec_ready low for 10 cycles at site 5 -> err_vec stays 0x20, rec_valid stays high and the record is stable, count is taken once; done at 115.
6. abort during SETTLE of site 8 -> err_vec=0 and busy=0 next cycle, no done, n_masked=8. Separately, rst_n low mid-SAMPLE -> all outputs 0 immediately.

Source files
------------

// File: rtl/fault_pkg.sv
// Shared types for the fault-injection campaign sequencer: FSM states,
// outcome classes and the outcome classifier.
package fault_pkg;

    localparam int CLASS_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_REPORT = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    typedef enum logic [CLASS_W-1:0] {
        CLS_MASKED      = 2'd0,
        CLS_DETECTED    = 2'd1,
        CLS_SILENT      = 2'd2,
        CLS_FALSE_ALARM = 2'd3
    } class_e;

    // Outcome of one run: does the sum match golden, and did the checker fire.
    function automatic class_e classify(input logic match, input logic det);
        class_e cls;
        case ({match, det})
            2'b10:   cls = CLS_MASKED;
            2'b01:   cls = CLS_DETECTED;
            2'b00:   cls = CLS_SILENT;
            2'b11:   cls = CLS_FALSE_ALARM;
            default: cls = CLS_MASKED;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for per-class outcome tallies.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;

    // Count up on inc, stick at the maximum, clear wins over inc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_q <= {CNT_W{1'b0}};
        end else if (inc && (count_q != CNT_MAX)) begin
            count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_q <= count_q;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fault_campaign_ctrl.sv
// Single-fault injection campaign sequencer: fault-free baseline, then a
// one-hot fault walked over every site, each result classified and streamed
// out as a record while per-class counters are kept.
module fault_campaign_ctrl
    import fault_pkg::*;
#(
    parameter int N_SITES = 20,
    parameter int OP_W    = 4,
    parameter int SETTLE  = 2,
    parameter int CNT_W   = 8,
    parameter int SITE_W  = $clog2(N_SITES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [OP_W-1:0]    a_in,
    input  logic [OP_W-1:0]    b_in,
    input  logic               cin_in,
    output logic [OP_W-1:0]    dut_a,
    output logic [OP_W-1:0]    dut_b,
    output logic               dut_cin,
    output logic [N_SITES-1:0] err_vec,
    input  logic [OP_W:0]      dut_result,
    input  logic               dut_err_det,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [SITE_W-1:0]  rec_site,
    output logic [CLASS_W-1:0] rec_class,
    output logic               busy,
    output logic               done,
    output logic               golden_fail,
    output logic [CNT_W-1:0]   n_masked,
    output logic [CNT_W-1:0]   n_detected,
    output logic [CNT_W-1:0]   n_silent,
    output logic [CNT_W-1:0]   n_false
);

    localparam int SETTLE_W = $clog2(SETTLE + 1);
    localparam logic [N_SITES-1:0] SITE0_HOT   = {{(N_SITES-1){1'b0}}, 1'b1};
    localparam logic [SITE_W-1:0]  LAST_SITE   = SITE_W'(N_SITES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LD  = SETTLE_W'(SETTLE);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE = {{(SETTLE_W-1){1'b0}}, 1'b1};

    state_e              state_q;
    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     b_q;
    logic                cin_q;
    logic [OP_W:0]       golden_q;
    logic [N_SITES-1:0]  err_vec_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [SITE_W-1:0]   site_q;
    logic                baseline_q;
    logic [OP_W:0]       res_q;
    logic                det_q;
    logic                rec_valid_q;
    class_e              rec_class_q;
    logic                busy_q;
    logic                done_q;
    logic                golden_fail_q;

    class_e              cls_s;
    logic                hs_s;
    logic                clr_s;
    logic [3:0]          inc_s;

    // Classify the sampled result against the golden sum.
    always_comb begin
        cls_s = classify(res_q == golden_q, det_q);
    end

    // Record handshake, counter increment selects and campaign-start clear.
    always_comb begin
        hs_s  = 1'b0;
        inc_s = 4'b0000;
        clr_s = (state_q == ST_IDLE) && start;
        if ((state_q == ST_REPORT) && rec_valid_q && rec_ready && !abort) begin
            hs_s = 1'b1;
            case (rec_class_q)
                CLS_MASKED:      inc_s = 4'b0001;
                CLS_DETECTED:    inc_s = 4'b0010;
                CLS_SILENT:      inc_s = 4'b0100;
                CLS_FALSE_ALARM: inc_s = 4'b1000;
                default:         inc_s = 4'b0000;
            endcase
        end else begin
            hs_s = 1'b0;
        end
    end

    // Campaign FSM with all control outputs registered; abort overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            a_q           <= {OP_W{1'b0}};
            b_q           <= {OP_W{1'b0}};
            cin_q         <= 1'b0;
            golden_q      <= {(OP_W+1){1'b0}};
            err_vec_q     <= {N_SITES{1'b0}};
            settle_q      <= {SETTLE_W{1'b0}};
            site_q        <= {SITE_W{1'b0}};
            baseline_q    <= 1'b0;
            res_q         <= {(OP_W+1){1'b0}};
            det_q         <= 1'b0;
            rec_valid_q   <= 1'b0;
            rec_class_q   <= CLS_MASKED;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            golden_fail_q <= 1'b0;
        end else if (abort && (state_q != ST_IDLE)) begin
            state_q     <= ST_IDLE;
            err_vec_q   <= {N_SITES{1'b0}};
            rec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q           <= a_in;
                        b_q           <= b_in;
                        cin_q         <= cin_in;
                        golden_q      <= {1'b0, a_in} + {1'b0, b_in} + {{OP_W{1'b0}}, cin_in};
                        golden_fail_q <= 1'b0;
                        busy_q        <= 1'b1;
                        baseline_q    <= 1'b1;
                        site_q        <= {SITE_W{1'b0}};
                        err_vec_q     <= {N_SITES{1'b0}};
                        state_q       <= ST_APPLY;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_APPLY: begin
                    settle_q <= SETTLE_LD;
                    state_q  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_ONE) begin
                        res_q   <= dut_result;
                        det_q   <= dut_err_det;
                        state_q <= ST_SAMPLE;
                    end else begin
                        settle_q <= settle_q - SETTLE_ONE;
                    end
                end
                ST_SAMPLE: begin
                    if (baseline_q) begin
                        if (cls_s != CLS_MASKED) begin
                            golden_fail_q <= 1'b1;
                            err_vec_q     <= {N_SITES{1'b0}};
                            done_q        <= 1'b1;
                            state_q       <= ST_DONE;
                        end else begin
                            baseline_q <= 1'b0;
                            site_q     <= {SITE_W{1'b0}};
                            err_vec_q  <= SITE0_HOT;
                            state_q    <= ST_APPLY;
                        end
                    end else begin
                        rec_class_q <= cls_s;
                        rec_valid_q <= 1'b1;
                        state_q     <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (hs_s) begin
                        rec_valid_q <= 1'b0;
                        if (site_q == LAST_SITE) begin
                            err_vec_q <= {N_SITES{1'b0}};
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            site_q    <= site_q + {{(SITE_W-1){1'b0}}, 1'b1};
                            err_vec_q <= SITE0_HOT << (site_q + {{(SITE_W-1){1'b0}}, 1'b1});
                            state_q   <= ST_APPLY;
                        end
                    end else begin
                        state_q <= ST_REPORT;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    err_vec_q   <= {N_SITES{1'b0}};
                    rec_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_masked (
        .clk(clk), .rst_n(rst_n), .clear(clr_s), .inc(inc_s[0]), .count(n_masked)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt_detected (
        .clk(clk), .rst_n(rst_n), .clear(clr_s), .inc(inc_s[1]), .count(n_detected)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt_silent (
        .clk(clk), .rst_n(rst_n), .clear(clr_s), .inc(inc_s[2]), .count(n_silent)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt_false (
        .clk(clk), .rst_n(rst_n), .clear(clr_s), .inc(inc_s[3]), .count(n_false)
    );

    assign dut_a       = a_q;
    assign dut_b       = b_q;
    assign dut_cin     = cin_q;
    assign err_vec     = err_vec_q;
    assign rec_valid   = rec_valid_q;
    assign rec_site    = site_q;
    assign rec_class   = rec_class_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign golden_fail = golden_fail_q;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Directed bench for fault_campaign_ctrl with a behavioural faulty-adder model.
module tb_fault_campaign_ctrl;

    localparam int N_SITES = 20;
    localparam int OP_W    = 4;
    localparam int SITE_W  = 5;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [OP_W-1:0]    a_in = '0;
    logic [OP_W-1:0]    b_in = '0;
    logic               cin_in = 1'b0;
    logic [OP_W-1:0]    dut_a;
    logic [OP_W-1:0]    dut_b;
    logic               dut_cin;
    logic [N_SITES-1:0] err_vec;
    logic [OP_W:0]      dut_result;
    logic               dut_err_det;
    logic               rec_valid;
    logic               rec_ready = 1'b1;
    logic [SITE_W-1:0]  rec_site;
    logic [1:0]         rec_class;
    logic               busy;
    logic               done;
    logic               golden_fail;
    logic [CNT_W-1:0]   n_masked;
    logic [CNT_W-1:0]   n_detected;
    logic [CNT_W-1:0]   n_silent;
    logic [CNT_W-1:0]   n_false;

    int n_checks = 0;
    int n_errors = 0;
    int mode = 0;

    int done_cyc;
    int rec_cnt;
    int hold_left;
    logic hold_bad;
    int rec_log [N_SITES];
    logic [OP_W:0] sum_s;

    always #5 clk = ~clk;

    fault_campaign_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
        .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin), .err_vec(err_vec),
        .dut_result(dut_result), .dut_err_det(dut_err_det),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_site(rec_site),
        .rec_class(rec_class), .busy(busy), .done(done), .golden_fail(golden_fail),
        .n_masked(n_masked), .n_detected(n_detected), .n_silent(n_silent), .n_false(n_false)
    );

    // Adder under test: ideal sum plus mode-selected fault behaviour.
    always_comb begin
        sum_s       = {1'b0, dut_a} + {1'b0, dut_b} + {4'b0000, dut_cin};
        dut_result  = sum_s;
        dut_err_det = 1'b0;
        case (mode)
            1: if (err_vec[3]) begin
                   dut_result  = sum_s ^ 5'b00001;
                   dut_err_det = 1'b1;
               end
            2: if (err_vec[7]) dut_result = sum_s ^ 5'b00010;
               else if (err_vec[12]) dut_err_det = 1'b1;
            3: if (err_vec == 20'h00000) dut_result = 5'd11;
            default: dut_result = sum_s;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one campaign; cycle 1 is the clock period right after the start edge.
    task automatic run_campaign(input logic [3:0] a, input logic [3:0] b, input logic c,
                                input int hold_site, input int abort_cyc, input int rst_cyc);
        int   cyc;
        logic fin;
        done_cyc = 0; rec_cnt = 0; hold_left = 10; hold_bad = 1'b0; fin = 1'b0;
        for (int i = 0; i < N_SITES; i++) rec_log[i] = -1;
        a_in = a; b_in = b; cin_in = c; rec_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!fin && cyc < 400) begin
            if (abort_cyc != 0 && cyc == abort_cyc + 1) begin
                abort = 1'b0;
                check_eq("abort_err_vec", 32'(err_vec), 32'h0);
                check_eq("abort_busy", 32'(busy), 32'h0);
                check_eq("abort_rec_valid", 32'(rec_valid), 32'h0);
                check_eq("abort_done", 32'(done), 32'h0);
                fin = 1'b1;
            end else if (rst_cyc != 0 && cyc == rst_cyc) begin
                check_eq("pre_rst_err_vec", 32'(err_vec), 32'h4);
                check_eq("pre_rst_masked", 32'(n_masked), 32'd2);
                rst_n = 1'b0;
                #1;
                check_eq("rst_err_vec", 32'(err_vec), 32'h0);
                check_eq("rst_busy", 32'(busy), 32'h0);
                check_eq("rst_rec_valid", 32'(rec_valid), 32'h0);
                check_eq("rst_masked", 32'(n_masked), 32'h0);
                check_eq("rst_dut_a", 32'(dut_a), 32'h0);
                fin = 1'b1;
            end else begin
                if (abort_cyc != 0 && cyc == abort_cyc) begin
                    check_eq("settle_err_vec", 32'(err_vec), 32'h100);
                    abort = 1'b1;
                end
                rec_ready = 1'b1;
                if (rec_valid && int'(rec_site) == hold_site && hold_left > 0) begin
                    rec_ready = 1'b0;
                    hold_left--;
                    if (err_vec !== 20'h00020 || rec_class !== 2'd0) hold_bad = 1'b1;
                end
                if (rec_valid && rec_ready && !abort) begin
                    check_eq("rec_site", 32'(rec_site), 32'(rec_cnt));
                    rec_log[rec_site] = int'(rec_class);
                    rec_cnt++;
                end
                if (done) begin
                    done_cyc = cyc;
                    fin = 1'b1;
                end
            end
            if (!fin) begin
                tick();
                cyc++;
            end
        end
        check_eq("campaign_finished", 32'(fin), 32'h1);
    endtask

    initial begin
        int done_seen;
        tick(); tick();
        check_eq("reset_err_vec", 32'(err_vec), 32'h0);
        check_eq("reset_busy", 32'(busy), 32'h0);
        check_eq("reset_done", 32'(done), 32'h0);
        check_eq("reset_rec_valid", 32'(rec_valid), 32'h0);
        check_eq("reset_golden_fail", 32'(golden_fail), 32'h0);
        check_eq("reset_counters", {n_masked, n_detected, n_silent, n_false}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Ideal adder: every site masked.
        mode = 0;
        run_campaign(4'd9, 4'd1, 1'b0, -1, 0, 0);
        check_eq("t1_done_cyc", 32'(done_cyc), 32'd105);
        check_eq("t1_records", 32'(rec_cnt), 32'd20);
        check_eq("t1_masked", 32'(n_masked), 32'd20);
        check_eq("t1_others", {8'h00, n_detected, n_silent, n_false}, 32'h0);
        check_eq("t1_golden_fail", 32'(golden_fail), 32'h0);
        check_eq("t1_cls19", 32'(rec_log[19]), 32'd0);
        check_eq("t1_operands", {23'h0, dut_a, dut_b, dut_cin}, {23'h0, 4'd9, 4'd1, 1'b0});
        check_eq("t1_done_err_vec", 32'(err_vec), 32'h0);
        tick();
        check_eq("t1_done_pulse", 32'(done), 32'h0);
        check_eq("t1_busy_after", 32'(busy), 32'h0);

        // Detected fault at site 3.
        mode = 1;
        run_campaign(4'd9, 4'd1, 1'b0, -1, 0, 0);
        check_eq("t2_cls3", 32'(rec_log[3]), 32'd1);
        check_eq("t2_detected", 32'(n_detected), 32'd1);
        check_eq("t2_masked", 32'(n_masked), 32'd19);
        check_eq("t2_done_cyc", 32'(done_cyc), 32'd105);
        tick();

        // Silent corruption at site 7, false alarm at site 12.
        mode = 2;
        run_campaign(4'd9, 4'd1, 1'b0, -1, 0, 0);
        check_eq("t3_cls7", 32'(rec_log[7]), 32'd2);
        check_eq("t3_cls12", 32'(rec_log[12]), 32'd3);
        check_eq("t3_silent", 32'(n_silent), 32'd1);
        check_eq("t3_false", 32'(n_false), 32'd1);
        check_eq("t3_masked", 32'(n_masked), 32'd18);
        tick();

        // Broken baseline aborts the campaign.
        mode = 3;
        run_campaign(4'd9, 4'd1, 1'b0, -1, 0, 0);
        check_eq("t4_done_cyc", 32'(done_cyc), 32'd5);
        check_eq("t4_golden_fail", 32'(golden_fail), 32'h1);
        check_eq("t4_records", 32'(rec_cnt), 32'd0);
        check_eq("t4_counters", {n_masked, n_detected, n_silent, n_false}, 32'h0);
        tick();
        check_eq("t4_golden_sticky", 32'(golden_fail), 32'h1);

        // Back-pressure on the site 5 record.
        mode = 0;
        run_campaign(4'd9, 4'd1, 1'b0, 5, 0, 0);
        check_eq("t5_done_cyc", 32'(done_cyc), 32'd115);
        check_eq("t5_masked", 32'(n_masked), 32'd20);
        check_eq("t5_hold_stable", 32'(hold_bad), 32'h0);
        check_eq("t5_hold_len", 32'(hold_left), 32'd0);
        check_eq("t5_golden_cleared", 32'(golden_fail), 32'h0);
        tick();

        // Abort during settle of site 8 (APPLY at cycle 45, SETTLE at 46).
        run_campaign(4'd9, 4'd1, 1'b0, -1, 46, 0);
        check_eq("t6_masked", 32'(n_masked), 32'd8);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) done_seen++;
        end
        check_eq("t6_no_done", 32'(done_seen), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'h0);

        // Asynchronous reset during SAMPLE of site 2 (cycle 18).
        run_campaign(4'd9, 4'd1, 1'b0, -1, 0, 18);
        rst_n = 1'b1;
        tick();
        check_eq("t7_idle_busy", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
